// File: rtl/rtx_pkg.sv
// Shared ray-tracer types: fixed-point vectors, camera, scheduler state and the
// per-ray record that travels on the shared core bus.
package rtx_pkg;

  typedef logic [23:0] fp24_t;

  typedef struct packed {
    fp24_t x;
    fp24_t y;
    fp24_t z;
  } fp24_vec3;

  typedef struct packed {
    fp24_vec3 origin;
    fp24_vec3 forward;
    fp24_vec3 right;
    fp24_vec3 up;
  } camera;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ray_sched_state_t;

  typedef struct packed {
    logic [10:0] pixel_h;
    logic [9:0]  pixel_v;
    fp24_vec3    origin;
    fp24_vec3    dir;
  } pixel_ray_t;

endpackage

// File: rtl/ray_scheduler_core_id_fifo.sv
// FIFO of reserved core indices, in issue order, so returning rays find their core.
module core_id_fifo #(
  parameter int NUM_CORES = 4,
  parameter int IW        = $clog2(NUM_CORES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [IW-1:0] push_id,
  input  logic          pop,
  output logic [IW-1:0] head,
  output logic          empty,
  output logic          full
);

  logic [IW-1:0] mem [NUM_CORES];
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_ptr;
  logic [IW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(NUM_CORES - 1)) ? '0 : p + IW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == (IW+1)'(NUM_CORES));
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + (IW+1)'(1);
        2'b01:   count <= count - (IW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ray_scheduler.sv
// Frame-level ray scheduler: paces the caster by free tracer cores, routes each
// returned ray to its reserved core and counts completions to end the frame.
module ray_scheduler
  import rtx_pkg::*;
#(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  camera                cam_in,
  output camera                cam,
  output logic                 new_ray,
  input  logic                 caster_valid,
  input  logic [10:0]          caster_pixel_h,
  input  logic [9:0]           caster_pixel_v,
  input  fp24_vec3             caster_origin,
  input  fp24_vec3             caster_dir,
  output logic [NUM_CORES-1:0] core_valid,
  output logic [10:0]          core_pixel_h,
  output logic [9:0]           core_pixel_v,
  output fp24_vec3             core_origin,
  output fp24_vec3             core_dir,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int IW    = $clog2(NUM_CORES);

  ray_sched_state_t     state;
  logic [CW-1:0]        issued;
  logic [CW-1:0]        completed;
  logic [CW-1:0]        done_cnt;
  logic [CW-1:0]        completed_nxt;
  logic [NUM_CORES-1:0] reserved;
  logic [NUM_CORES-1:0] done_eff;
  logic [NUM_CORES-1:0] grant_mask;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        fifo_head;
  logic                 grant_found;
  logic                 issue;
  logic                 ret_ok;
  logic                 fifo_empty;
  logic                 fifo_full;
  int unsigned          cand;
  pixel_ray_t           core_bus;

  // Round-robin search starts just after the last granted core.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_CORES;
      if (!grant_found && !reserved[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  assign issue      = (state == RUN) && (issued < CW'(TOTAL)) && grant_found;
  assign new_ray    = issue;
  assign grant_mask = issue ? (NUM_CORES'(1) << grant_idx) : '0;

  // Stray done pulses from cores we never reserved (e.g. after reset) are ignored.
  assign done_eff = core_done & reserved;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) done_cnt = done_cnt + CW'(done_eff[i]);
  end

  assign completed_nxt = completed + done_cnt;
  assign ret_ok        = caster_valid && !fifo_empty;

  core_id_fifo #(
    .NUM_CORES(NUM_CORES),
    .IW       (IW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (issue),
    .push_id(grant_idx),
    .pop    (ret_ok),
    .head   (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cam        <= '0;
      issued     <= '0;
      completed  <= '0;
      reserved   <= '0;
      rr_ptr     <= IW'(NUM_CORES - 1);
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      core_valid <= '0;
      core_bus   <= '0;
    end else begin
      frame_done <= 1'b0;
      core_valid <= '0;
      reserved   <= (reserved & ~done_eff) | grant_mask;
      completed  <= completed_nxt;
      if (issue) begin
        issued <= issued + CW'(1);
        rr_ptr <= grant_idx;
      end
      if (ret_ok) begin
        core_valid       <= NUM_CORES'(1) << fifo_head;
        core_bus.pixel_h <= caster_pixel_h;
        core_bus.pixel_v <= caster_pixel_v;
        core_bus.origin  <= caster_origin;
        core_bus.dir     <= caster_dir;
      end
      if (caster_valid && fifo_empty) err <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_start) begin
            cam       <= cam_in;
            issued    <= '0;
            completed <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (issued == CW'(TOTAL)) state <= DRAIN;
        end
        DRAIN: begin
          if (completed_nxt == CW'(TOTAL)) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_pixel_h = core_bus.pixel_h;
  assign core_pixel_v = core_bus.pixel_v;
  assign core_origin  = core_bus.origin;
  assign core_dir     = core_bus.dir;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ray_scheduler.sv
// Bench: a 4x2 frame on a 2-core instance with caster/core models and a ray
// scoreboard, plus a 4-core instance driven directly for round-robin order.
module tb_ray_scheduler;
  import rtx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- 2-core instance ----------------
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  camera      cam_in = '0;
  camera      cam;
  logic       new_ray;
  logic       caster_valid;
  pixel_ray_t m_ray = '0;
  logic       m_cv = 1'b0;
  logic       man_cv = 1'b0;
  logic [1:0] core_valid;
  logic [10:0] core_pixel_h;
  logic [9:0]  core_pixel_v;
  fp24_vec3   core_origin;
  fp24_vec3   core_dir;
  logic [1:0] core_done;
  logic [1:0] m_done = '0;
  logic [1:0] man_done = '0;
  logic       busy, frame_done, err;

  assign caster_valid = m_cv | man_cv;
  assign core_done    = m_done | man_done;

  ray_scheduler #(.WIDTH(4), .HEIGHT(2), .NUM_CORES(2)) d2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cam_in(cam_in), .cam(cam),
    .new_ray(new_ray), .caster_valid(caster_valid),
    .caster_pixel_h(m_ray.pixel_h), .caster_pixel_v(m_ray.pixel_v),
    .caster_origin(m_ray.origin), .caster_dir(m_ray.dir),
    .core_valid(core_valid), .core_pixel_h(core_pixel_h), .core_pixel_v(core_pixel_v),
    .core_origin(core_origin), .core_dir(core_dir), .core_done(core_done),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  typedef struct {
    int         t;
    pixel_ray_t ray;
  } pend_t;

  pend_t      cq[$];
  pixel_ray_t sb[$];
  int         done_at[2] = '{-1, -1};
  int         px_h = 0, px_v = 0;
  int         nr_count = 0, fd_count = 0, disp_total = 0, last_core = -1;
  int         dispatched[8];
  logic       hold = 1'b0;

  function automatic pixel_ray_t make_ray(input int h, input int v);
    pixel_ray_t r;
    r.pixel_h  = 11'(h);
    r.pixel_v  = 10'(v);
    r.origin.x = 24'(h * 7 + 1);
    r.origin.y = 24'(v * 13 + 2);
    r.origin.z = 24'h00A5A5;
    r.dir.x    = 24'hC00000 ^ 24'(h);
    r.dir.y    = 24'h300000 ^ 24'(v << 4);
    r.dir.z    = 24'(h * 256 + v);
    return r;
  endfunction

  // Caster model (latency 3), core model (done 5 cycles after dispatch), scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      cq.delete();
      sb.delete();
      done_at = '{-1, -1};
      px_h = 0;
      px_v = 0;
      m_cv = 1'b0;
      m_done = '0;
    end else begin
      m_done = '0;
      for (int i = 0; i < 2; i++) if (done_at[i] == cyc) m_done[i] = 1'b1;
      m_cv = 1'b0;
      if (cq.size() > 0 && cq[0].t == cyc) begin
        pend_t p;
        p = cq.pop_front();
        m_cv  = 1'b1;
        m_ray = p.ray;
        sb.push_back(p.ray);
      end
      if (new_ray) begin
        pend_t p;
        nr_count++;
        p.t   = cyc + 3;
        p.ray = make_ray(px_h, px_v);
        cq.push_back(p);
        px_h++;
        if (px_h == 4) begin
          px_h = 0;
          px_v = (px_v + 1) % 2;
        end
      end
      if (frame_done) fd_count++;
      if (|core_valid) begin
        pixel_ray_t obs;
        int idx;
        idx = core_valid[1] ? 1 : 0;
        obs.pixel_h = core_pixel_h;
        obs.pixel_v = core_pixel_v;
        obs.origin  = core_origin;
        obs.dir     = core_dir;
        check("core_valid_onehot", 320'($onehot(core_valid)), 320'(1));
        if (sb.size() == 0) check("dispatch_without_return", 320'(1), 320'(0));
        else check("dispatch_ray", obs, sb.pop_front());
        if (int'(core_pixel_v) < 2 && int'(core_pixel_h) < 4)
          dispatched[int'(core_pixel_v) * 4 + int'(core_pixel_h)]++;
        disp_total++;
        last_core = idx;
        if (!hold) done_at[idx] = cyc + 5;
      end
    end
  end

  // ---------------- 4-core instance ----------------
  logic       rst4 = 1'b1;
  logic       fs4 = 1'b0;
  logic       cv4 = 1'b0;
  logic [3:0] done4 = '0;
  camera      cam4;
  logic       nr4, busy4, fd4, err4;
  logic [3:0] corev4;
  logic [10:0] cph4;
  logic [9:0]  cpv4;
  fp24_vec3   co4, cd4;
  fp24_vec3   zero_vec = '0;

  ray_scheduler #(.WIDTH(4), .HEIGHT(2), .NUM_CORES(4)) d4 (
    .clk(clk), .rst(rst4), .frame_start(fs4), .cam_in(camera'('0)), .cam(cam4),
    .new_ray(nr4), .caster_valid(cv4),
    .caster_pixel_h(11'd0), .caster_pixel_v(10'd0),
    .caster_origin(zero_vec), .caster_dir(zero_vec),
    .core_valid(corev4), .core_pixel_h(cph4), .core_pixel_v(cpv4),
    .core_origin(co4), .core_dir(cd4), .core_done(done4),
    .busy(busy4), .frame_done(fd4), .err(err4)
  );

  task automatic clear_counts();
    nr_count = 0;
    fd_count = 0;
    disp_total = 0;
    last_core = -1;
    for (int i = 0; i < 8; i++) dispatched[i] = 0;
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int n;
    n = 0;
    while (fd_count == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 320'(fd_count != 0), 320'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_full_frame(input string tag);
    check({tag, "_new_ray_count"}, 320'(nr_count), 320'(8));
    check({tag, "_frame_done_count"}, 320'(fd_count), 320'(1));
    check({tag, "_busy_after"}, 320'(busy), 320'(0));
    for (int i = 0; i < 8; i++) check({tag, "_pixel_once"}, 320'(dispatched[i]), 320'(1));
  endtask

  camera cam_a, cam_b;

  initial begin
    cam_a = {12{24'h13579B}};
    cam_b = {12{24'h2468AC}};
    clear_counts();
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;

    // reset state
    check("rst_new_ray", 320'(new_ray), 320'(0));
    check("rst_core_valid", 320'(core_valid), 320'(0));
    check("rst_busy", 320'(busy), 320'(0));
    check("rst_frame_done", 320'(frame_done), 320'(0));
    check("rst_err", 320'(err), 320'(0));
    check("rst_cam", cam, 320'(0));
    check("rst_bus", 320'({core_pixel_h, core_pixel_v, core_origin, core_dir}), 320'(0));

    // basic frame, camera changed mid-frame must not leak through
    cam_in = cam_a;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cam_in = cam_b;
    check("first_new_ray", 320'(new_ray), 320'(1));
    check("busy_in_frame", 320'(busy), 320'(1));
    wait_frame("basic_frame_done_timeout", 300);
    check_full_frame("basic");
    check("cam_stable", cam, cam_a);
    check("basic_err", 320'(err), 320'(0));

    // throttle: cores hold their rays
    clear_counts();
    hold = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (30) @(negedge clk);
    check("throttle_new_ray_count", 320'(nr_count), 320'(2));
    check("throttle_busy", 320'(busy), 320'(1));
    man_done = 2'b10;
    @(negedge clk);
    man_done = 2'b00;
    repeat (15) @(negedge clk);
    check("release_new_ray_count", 320'(nr_count), 320'(3));
    check("release_dispatch_count", 320'(disp_total), 320'(3));
    check("release_core", 320'(last_core), 320'(1));

    // reset mid-frame after 3 issues
    rst = 1'b1;
    @(negedge clk);
    check("midrst_new_ray", 320'(new_ray), 320'(0));
    check("midrst_core_valid", 320'(core_valid), 320'(0));
    check("midrst_busy", 320'(busy), 320'(0));
    check("midrst_err", 320'(err), 320'(0));
    check("midrst_cam", cam, 320'(0));
    check("midrst_state", 320'(d2.state), 320'(IDLE));
    rst = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    clear_counts();
    cam_in = cam_b;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_frame("postrst_frame_done_timeout", 300);
    check_full_frame("postrst");
    check("postrst_cam", cam, cam_b);

    // spurious caster_valid in IDLE
    clear_counts();
    man_cv = 1'b1;
    @(negedge clk);
    man_cv = 1'b0;
    @(negedge clk);
    check("spurious_err", 320'(err), 320'(1));
    repeat (5) @(negedge clk);
    check("spurious_no_dispatch", 320'(disp_total), 320'(0));
    check("spurious_err_sticky", 320'(err), 320'(1));
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_frame("after_err_frame_done_timeout", 300);
    check_full_frame("after_err");
    check("after_err_err_sticky", 320'(err), 320'(1));

    // round-robin on 4 cores
    fs4 = 1'b1;
    @(negedge clk);
    fs4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rr_issue", 320'(nr4), 320'(1));
      @(negedge clk);
    end
    check("rr_all_reserved", 320'(nr4), 320'(0));
    for (int i = 0; i < 4; i++) begin
      cv4 = 1'b1;
      @(negedge clk);
      check("rr_grant_order", 320'(corev4), 320'(4'b0001 << i));
    end
    cv4 = 1'b0;

    // simultaneous completion of cores 0 and 1
    done4 = 4'b0011;
    check("simul_no_same_cycle_grant", 320'(nr4), 320'(0));
    @(negedge clk);
    done4 = 4'b0000;
    check("simul_completed", 320'(d4.completed), 320'(2));
    check("simul_regrant_a", 320'(nr4), 320'(1));
    @(negedge clk);
    check("simul_regrant_b", 320'(nr4), 320'(1));
    @(negedge clk);
    check("simul_regrant_stop", 320'(nr4), 320'(0));
    for (int i = 0; i < 2; i++) begin
      cv4 = 1'b1;
      @(negedge clk);
      check("simul_regrant_core", 320'(corev4), 320'(4'b0001 << i));
    end
    cv4 = 1'b0;
    @(negedge clk);
    check("rr_err", 320'(err4), 320'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
